// File: rtl/ctu_tsr_pkg.sv
// Shared constants for the temperature-sensor readout controller:
// FSM state encodings, parameter defaults and the WAIT blanking length.
package ctu_tsr_pkg;

    localparam int unsigned TSR_DW_DEF       = 8;
    localparam int unsigned TSR_DIV_DEF      = 4;
    localparam int unsigned TSR_TIMEOUT_DEF  = 1023;
    localparam int unsigned TSR_INTERVAL_DEF = 4096;

    // Cycles at the head of WAIT during which the synchronized busy is ignored
    localparam int unsigned TSR_BLANK = 4;

    typedef logic [2:0] tsr_state_t;

    localparam tsr_state_t ST_IDLE  = 3'd0;
    localparam tsr_state_t ST_START = 3'd1;
    localparam tsr_state_t ST_WAIT  = 3'd2;
    localparam tsr_state_t ST_SHIFT = 3'd3;
    localparam tsr_state_t ST_DONE  = 3'd4;
    localparam tsr_state_t ST_ERR   = 3'd5;

endpackage

// File: rtl/ctu_tsr_sync.sv
// Two-flop synchronizer for asynchronous sensor inputs into the jbus_clk domain.
module ctu_tsr_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ctu_tsr_ctl.sv
// Temperature-sensor readout controller: starts conversions, waits with timeout,
// shifts the serial result in on a generated clock and serves req/ack reads.
module ctu_tsr_ctl
    import ctu_tsr_pkg::*;
#(
    parameter int unsigned DW       = TSR_DW_DEF,
    parameter int unsigned DIV      = TSR_DIV_DEF,
    parameter int unsigned TIMEOUT  = TSR_TIMEOUT_DEF,
    parameter int unsigned INTERVAL = TSR_INTERVAL_DEF
) (
    input  logic          jbus_clk,
    input  logic          jbus_rst,
    output logic          tsr_start,
    input  logic          tsr_busy,
    output logic          tsr_sclk,
    input  logic          tsr_sdo,
    input  logic          auto_en,
    input  logic [DW-1:0] thresh_hi,
    input  logic [DW-1:0] thresh_lo,
    input  logic          rd_req,
    output logic          rd_ack,
    output logic [DW-1:0] rd_data,
    output logic          rd_err,
    output logic          overtemp
);

    localparam int unsigned WCW = $clog2(TIMEOUT);
    localparam int unsigned ICW = $clog2(INTERVAL);
    localparam int unsigned PCW = $clog2(DIV);
    localparam int unsigned BCW = $clog2(DW);

    tsr_state_t    state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [ICW-1:0] int_cnt_q, int_cnt_d;
    logic [PCW-1:0] phase_q, phase_d;
    logic [BCW-1:0] bit_q, bit_d;
    logic           sclk_q, sclk_d;
    logic [DW-1:0]  shreg_q, shreg_d;
    logic [DW-1:0]  result_q, result_d;
    logic           ovt_q, ovt_d;
    logic           pend_q, pend_d;
    logic           ack_d1_q, ack_d1_d;

    logic busy_s;
    logic sdo_s;
    logic req_new;
    logic ack_c;
    logic int_hit;

    ctu_tsr_sync u_sync_busy (
        .clk (jbus_clk),
        .rst (jbus_rst),
        .d   (tsr_busy),
        .q   (busy_s)
    );

    ctu_tsr_sync u_sync_sdo (
        .clk (jbus_clk),
        .rst (jbus_rst),
        .d   (tsr_sdo),
        .q   (sdo_s)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        int_cnt_d  = int_cnt_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        sclk_d     = sclk_q;
        shreg_d    = shreg_q;
        result_d   = result_q;
        ovt_d      = ovt_q;

        // The sample in the cycle right after an ack is the requester's trailing level
        req_new  = rd_req & ~ack_d1_q;
        ack_c    = pend_q & ((state_q == ST_DONE) || (state_q == ST_ERR));
        pend_d   = ack_c ? 1'b0 : (pend_q | req_new);
        ack_d1_d = ack_c;
        int_hit  = auto_en && (int_cnt_q == ICW'(INTERVAL - 1));

        case (state_q)
            ST_IDLE: begin
                if (auto_en && !int_hit) begin
                    int_cnt_d = int_cnt_q + 1'b1;
                end
                if (pend_q || req_new || int_hit) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                int_cnt_d  = '0;
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if ((wait_cnt_q >= WCW'(TSR_BLANK - 1)) && !busy_s) begin
                    phase_d = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                    state_d = ST_SHIFT;
                end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (phase_q == PCW'(DIV - 1)) begin
                    phase_d = '0;
                    if (!sclk_q) begin
                        sclk_d  = 1'b1;
                        shreg_d = {shreg_q[DW-2:0], sdo_s};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == BCW'(DW - 1)) begin
                            // Result and flag are loaded on DONE entry so they are valid alongside rd_ack
                            result_d = shreg_q;
                            if (shreg_q >= thresh_hi) begin
                                ovt_d = 1'b1;
                            end else if (shreg_q <= thresh_lo) begin
                                ovt_d = 1'b0;
                            end
                            state_d = ST_DONE;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge jbus_clk) begin
        if (jbus_rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            int_cnt_q  <= '0;
            phase_q    <= '0;
            bit_q      <= '0;
            sclk_q     <= 1'b0;
            shreg_q    <= '0;
            result_q   <= '0;
            ovt_q      <= 1'b0;
            pend_q     <= 1'b0;
            ack_d1_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            int_cnt_q  <= int_cnt_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            sclk_q     <= sclk_d;
            shreg_q    <= shreg_d;
            result_q   <= result_d;
            ovt_q      <= ovt_d;
            pend_q     <= pend_d;
            ack_d1_q   <= ack_d1_d;
        end
    end

    assign tsr_start = (state_q == ST_START);
    assign tsr_sclk  = sclk_q;
    assign rd_ack    = ack_c;
    assign rd_err    = pend_q & (state_q == ST_ERR);
    assign rd_data   = result_q;
    assign overtemp  = ovt_q;

endmodule

// File: tb/tb_ctu_tsr_ctl.sv
// Directed bench for ctu_tsr_ctl with a behavioural sensor: read latency,
// timeout, hysteresis, auto sampling, mid-shift reset and back-to-back reads.
module tb_ctu_tsr_ctl;

    logic       jbus_clk = 1'b0;
    logic       jbus_rst;
    logic       tsr_start;
    logic       tsr_busy;
    logic       tsr_sclk;
    logic       tsr_sdo;
    logic       auto_en;
    logic [7:0] thresh_hi;
    logic [7:0] thresh_lo;
    logic       rd_req;
    logic       rd_ack;
    logic [7:0] rd_data;
    logic       rd_err;
    logic       overtemp;

    int         nvec = 0;
    int         nmis = 0;

    logic [7:0] sens_data  = 8'h00;
    int         sens_busy  = 0;
    logic       sens_stuck = 1'b0;

    always #5 jbus_clk = ~jbus_clk;

    ctu_tsr_ctl #(.DW(8), .DIV(4), .TIMEOUT(40), .INTERVAL(16)) dut (
        .jbus_clk  (jbus_clk),
        .jbus_rst  (jbus_rst),
        .tsr_start (tsr_start),
        .tsr_busy  (tsr_busy),
        .tsr_sclk  (tsr_sclk),
        .tsr_sdo   (tsr_sdo),
        .auto_en   (auto_en),
        .thresh_hi (thresh_hi),
        .thresh_lo (thresh_lo),
        .rd_req    (rd_req),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data),
        .rd_err    (rd_err),
        .overtemp  (overtemp)
    );

    // Sensor model: busy for sens_busy cycles after tsr_start, then MSB-first data
    // advanced one bit per rising tsr_sclk.
    initial begin
        logic prev;
        int   idx;
        int   cnt;
        tsr_busy = 1'b0;
        tsr_sdo  = 1'b0;
        prev = 1'b0;
        idx  = 0;
        cnt  = 0;
        forever begin
            @(negedge jbus_clk);
            if (tsr_start) begin
                cnt = sens_busy;
                idx = 0;
                if (cnt == 0) begin
                    tsr_busy = 1'b0;
                    tsr_sdo  = sens_data[7];
                end else begin
                    tsr_busy = 1'b1;
                end
            end else if (tsr_busy && !sens_stuck) begin
                cnt = cnt - 1;
                if (cnt <= 0) begin
                    tsr_busy = 1'b0;
                    tsr_sdo  = sens_data[7];
                end
            end
            if (tsr_sclk && !prev) begin
                idx = idx + 1;
                if (idx < 8) tsr_sdo = sens_data[7-idx];
            end
            prev = tsr_sclk;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Raises rd_req at the current negedge and follows the transaction to rd_ack.
    // n counts negedges from the request (n=1 is the cycle after it is sampled).
    task automatic run_conv(input int budget, output int ack_n, output int starts,
                            output int rises, output int first_rise, output int last_rise,
                            output logic err, output logic [7:0] data, output logic ovt);
        logic prev_sclk;
        ack_n = -1; starts = 0; rises = 0; first_rise = -1; last_rise = -1;
        err = 1'b0; data = 8'h00; ovt = 1'b0; prev_sclk = 1'b0;
        rd_req = 1'b1;
        for (int n = 1; n <= budget && ack_n < 0; n++) begin
            @(negedge jbus_clk);
            if (tsr_start) starts++;
            if (tsr_sclk && !prev_sclk) begin
                rises++;
                if (first_rise < 0) first_rise = n;
                last_rise = n;
            end
            prev_sclk = tsr_sclk;
            if (rd_ack) begin
                ack_n = n;
                err   = rd_err;
                data  = rd_data;
                ovt   = overtemp;
            end
        end
        if (ack_n >= 0) begin
            // Hold through the cycle after ack, which the DUT must ignore
            @(negedge jbus_clk);
            @(negedge jbus_clk);
        end
        rd_req = 1'b0;
    endtask

    task automatic quiet(input int cycles, output int starts, output int acks);
        starts = 0;
        acks   = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge jbus_clk);
            if (tsr_start) starts++;
            if (rd_ack) acks++;
        end
    endtask

    initial begin
        int         ack_n, starts, rises, fr, lr, acks, s1, s2;
        logic       err, ovt;
        logic [7:0] data;
        logic       prev_sclk;
        logic [7:0] hyst_val [4];
        logic       hyst_ovt [4];

        jbus_rst  = 1'b1;
        rd_req    = 1'b0;
        auto_en   = 1'b0;
        thresh_hi = 8'hFF;
        thresh_lo = 8'h00;
        repeat (3) @(negedge jbus_clk);
        jbus_rst = 1'b0;
        @(negedge jbus_clk);

        chk("rst_start", {31'd0, tsr_start}, 32'd0);
        chk("rst_sclk",  {31'd0, tsr_sclk},  32'd0);
        chk("rst_ack",   {31'd0, rd_ack},    32'd0);
        chk("rst_err",   {31'd0, rd_err},    32'd0);
        chk("rst_data",  {24'd0, rd_data},   32'd0);
        chk("rst_ovt",   {31'd0, overtemp},  32'd0);

        // Nominal read: busy 20 cycles, result 0xA5
        sens_data = 8'hA5;
        sens_busy = 20;
        run_conv(300, ack_n, starts, rises, fr, lr, err, data, ovt);
        chk("nom_ack_n",  ack_n,  88);
        chk("nom_starts", starts, 1);
        chk("nom_rises",  rises,  8);
        chk("nom_first",  fr,     28);
        chk("nom_span",   lr - fr, 56);
        chk("nom_err",    {31'd0, err}, 32'd0);
        chk("nom_data",   {24'd0, data}, 32'h A5);
        chk("nom_ovt",    {31'd0, ovt}, 32'd0);

        // Timeout: busy stuck high
        sens_stuck = 1'b1;
        sens_busy  = 5;
        run_conv(300, ack_n, starts, rises, fr, lr, err, data, ovt);
        chk("to_ack_n",  ack_n, 42);
        chk("to_err",    {31'd0, err}, 32'd1);
        chk("to_data",   {24'd0, data}, 32'h A5);
        chk("to_rises",  rises, 0);
        sens_stuck = 1'b0;
        quiet(12, starts, acks);
        chk("to_err_low", {31'd0, rd_err}, 32'd0);

        // Hysteresis sequence with immediate busy release
        thresh_hi = 8'h60;
        thresh_lo = 8'h50;
        sens_busy = 0;
        hyst_val[0] = 8'h58; hyst_ovt[0] = 1'b0;
        hyst_val[1] = 8'h60; hyst_ovt[1] = 1'b1;
        hyst_val[2] = 8'h55; hyst_ovt[2] = 1'b1;
        hyst_val[3] = 8'h50; hyst_ovt[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sens_data = hyst_val[k];
            run_conv(300, ack_n, starts, rises, fr, lr, err, data, ovt);
            chk($sformatf("hy%0d_ack_n", k), ack_n, 70);
            chk($sformatf("hy%0d_first", k), fr, 10);
            chk($sformatf("hy%0d_data", k), {24'd0, data}, {24'd0, hyst_val[k]});
            chk($sformatf("hy%0d_ovt", k), {31'd0, ovt}, {31'd0, hyst_ovt[k]});
        end

        // Auto mode: starts 16 IDLE cycles apart, no acks
        sens_data = 8'h3C;
        auto_en = 1'b1;
        s1 = -1; s2 = -1; acks = 0;
        for (int n = 1; n <= 250 && s2 < 0; n++) begin
            @(negedge jbus_clk);
            if (rd_ack) acks++;
            if (tsr_start) begin
                if (s1 < 0) s1 = n;
                else s2 = n;
            end
        end
        chk("auto_first", s1, 16);
        chk("auto_space", s2 - s1, 86);
        chk("auto_noack", acks, 0);
        repeat (30) @(negedge jbus_clk);
        // Request raised mid-SHIFT is served by the running conversion
        rd_req = 1'b1;
        ack_n = -1; starts = 0;
        for (int n = 1; n <= 200 && ack_n < 0; n++) begin
            @(negedge jbus_clk);
            if (tsr_start) starts++;
            if (rd_ack) begin
                ack_n = n;
                err   = rd_err;
                data  = rd_data;
                auto_en = 1'b0;
            end
        end
        chk("auto_ack_n", ack_n, 39);
        chk("auto_nostart", starts, 0);
        chk("auto_err", {31'd0, err}, 32'd0);
        chk("auto_data", {24'd0, data}, 32'h3C);
        @(negedge jbus_clk);
        @(negedge jbus_clk);
        rd_req = 1'b0;
        quiet(40, starts, acks);
        chk("auto_off_starts", starts, 0);

        // Reset after the 4th sclk rise
        sens_data = 8'hC3;
        rd_req = 1'b1;
        rises = 0; prev_sclk = 1'b0;
        for (int n = 1; n <= 200 && rises < 4; n++) begin
            @(negedge jbus_clk);
            if (tsr_sclk && !prev_sclk) rises++;
            prev_sclk = tsr_sclk;
        end
        chk("mid_rises", rises, 4);
        jbus_rst = 1'b1;
        rd_req   = 1'b0;
        @(negedge jbus_clk);
        jbus_rst = 1'b0;
        chk("mrst_sclk",  {31'd0, tsr_sclk},  32'd0);
        chk("mrst_start", {31'd0, tsr_start}, 32'd0);
        chk("mrst_ack",   {31'd0, rd_ack},    32'd0);
        chk("mrst_err",   {31'd0, rd_err},    32'd0);
        chk("mrst_data",  {24'd0, rd_data},   32'd0);
        chk("mrst_ovt",   {31'd0, overtemp},  32'd0);
        quiet(90, starts, acks);
        chk("mrst_noack",   acks,   0);
        chk("mrst_nostart", starts, 0);
        run_conv(300, ack_n, starts, rises, fr, lr, err, data, ovt);
        chk("post_ack_n", ack_n, 70);
        chk("post_data",  {24'd0, data}, 32'h C3);

        // Back-to-back: re-raised two cycles after ack
        sens_data = 8'h61;
        run_conv(300, ack_n, starts, rises, fr, lr, err, data, ovt);
        chk("b2b1_ack_n", ack_n, 70);
        chk("b2b1_ovt",   {31'd0, ovt}, 32'd1);
        sens_data = 8'h59;
        run_conv(300, ack_n, starts, rises, fr, lr, err, data, ovt);
        chk("b2b2_ack_n",  ack_n, 70);
        chk("b2b2_starts", starts, 1);
        chk("b2b2_data",   {24'd0, data}, 32'h59);
        chk("b2b2_ovt",    {31'd0, ovt}, 32'd1);
        quiet(10, starts, acks);
        chk("b2b_spurious", starts, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/ctu_tsr_ctl.md
# ctu_tsr_ctl

Temperature-sensor readout controller in the clock/test unit, on the core side of the tempsensor test pins in the CTU pad cluster. It starts conversions in the analog sensor, waits for completion with a timeout, and shifts the serial result in on a generated clock. It serves software reads through a req/ack handshake and keeps a hysteretic over-temperature flag. Conversions are launched on request or periodically.

## Interface
- DW, 8: result width (bits)
- DIV, 4: tsr_sclk half-period in jbus_clk cycles; legal range ≥3
- TIMEOUT, 1023: maximum WAIT cycles before error
- INTERVAL, 4096: auto-sample period in IDLE cycles

Ports:
- jbus_clk  in  1  sole clock
- jbus_rst  in  1  reset; synchronous, active-high
- tsr_start  out  1  one-cycle conversion-start pulse to sensor
- tsr_busy  in  1  sensor converting; asynchronous, synchronized internally
- tsr_sclk  out  1  serial shift clock to sensor
- tsr_sdo  in  1  serial result from sensor, MSB first; asynchronous, synchronized internally
- auto_en  in  1  enables periodic conversions
- thresh_hi  in  DW  over-temp set threshold (unsigned)
- thresh_lo  in  DW  over-temp clear threshold (unsigned, ≤ thresh_hi)
- rd_req  in  1  software read request, level
- rd_ack  out  1  one-cycle read completion pulse
- rd_data  out  DW  last good result; valid with rd_ack, held afterwards
- rd_err  out  1  qualifies rd_ack: conversion timed out
- overtemp  out  1  hysteretic over-temperature flag

## Operation
- States: IDLE, START, WAIT, SHIFT, DONE, ERR.
- IDLE → START:
  - when a request is pending, or
  - when auto_en=1 and the interval counter reaches INTERVAL-1.
  - A pending request has priority only in the sense that both take the same path.
- START: tsr_start=1 for exactly this cycle → WAIT. The interval counter clears here.
- WAIT: the synchronized busy is ignored for the first 4 cycles.
  - Synchronized busy=0 afterwards → SHIFT.
  - WAIT cycle count reaching TIMEOUT → ERR.
- SHIFT:
  - tsr_sclk runs DIV cycles low, then DIV cycles high, for DW periods.
  - Synchronized sdo is shifted in on the cycle tsr_sclk rises.
  - After the DW-th high phase, tsr_sclk returns low → DONE.
- DONE:
  - Load the shift register into the result register (rd_data).
  - Update overtemp: set if result ≥ thresh_hi; clear if result ≤ thresh_lo; otherwise hold.
  - If a request is pending: rd_ack=1, rd_err=0.
  - → IDLE.
- ERR:
  - rd_data and overtemp unchanged.
  - If a request is pending: rd_ack=1, rd_err=1.
  - → IDLE.
- Request pending flag:
  - Set when rd_req=1 in any state, except the cycle immediately after rd_ack.
  - Cleared with rd_ack.
  - A request arriving during an auto conversion is served by that conversion.
- The interval counter advances only in IDLE with auto_en=1 and saturates at INTERVAL-1. It holds when auto_en=0.

## Timing
- Reset values: all outputs 0, rd_data 0, overtemp 0, state IDLE, all counters 0, pending flag 0, synchronizer flops 0.
- Reset mid-operation: the conversion is aborted and tsr_sclk is low the cycle after reset. A pending request is dropped without rd_ack.
- rd_req sampled high in IDLE at cycle t: tsr_start=1 at t+1.
- With busy already low: SHIFT begins at t+6, DONE at t+6+2·DIV·DW, rd_ack one cycle after DONE entry registers, i.e. rd_ack is high in the DONE cycle.
- Defaults (DW=8, DIV=4): rd_ack at t+70.
- Requester rule: hold rd_req until rd_ack; drop rd_req the cycle after rd_ack. rd_req sampled in that cycle is ignored.
- Synchronizers add 2 cycles to busy/sdo. DIV≥3 guarantees sdo is stable when sampled.
- rd_err is only meaningful when rd_ack=1; it is 0 otherwise.

## Structure
- Package ctu_tsr_pkg holds:
  - the state enumeration;
  - default constants for DW, DIV, TIMEOUT and INTERVAL;
  - the WAIT blanking length (4).
- One sub-module, ctu_tsr_sync: a 2-flop synchronizer, instantiated for tsr_busy and tsr_sdo.
- The FSM, counters, shift register and overtemp logic stay in ctu_tsr_ctl.

## Test plan
- Read, nominal: rd_req=1, sensor busy for 20 cycles, then serializes 0xA5 → one tsr_start pulse, 8 sclk periods of 8 cycles, rd_ack with rd_data=0xA5, rd_err=0.
- Timeout: busy stuck high → rd_ack with rd_err=1 exactly TIMEOUT cycles into WAIT; rd_data keeps the prior 0xA5.
- Hysteresis: thresh_hi=0x60, thresh_lo=0x50, results 0x58, 0x60, 0x55, 0x50 → overtemp 0, 1, 1, 0.
- Auto mode: auto_en=1, INTERVAL=16 → tsr_start spaced 16 IDLE cycles apart; no rd_ack. A rd_req raised mid-SHIFT is acked at that conversion's DONE with no second tsr_start.
- Reset mid-SHIFT: jbus_rst after bit 3 → next cycle all outputs 0; no rd_ack. A subsequent request completes normally.
- Back-to-back: rd_req re-raised 2 cycles after rd_ack → second conversion; the cycle-after-ack sample does not create a spurious pending request.
